// File: rtl/aska_spi_readback.sv
// SPI Mode 0 readback slave for the ASKA config interface: decodes a read command
// byte, then shifts one 32-bit config word and its CRC-8 out on SPI_MISO.
module aska_spi_readback #(
  parameter logic [7:0] CRC_POLY  = 8'h07,
  parameter logic [5:0] RD_OPCODE = 6'h28
) (
  input  logic        SPI_Clk,
  input  logic        resetn,
  input  logic        SPI_CS,
  input  logic        SPI_MOSI,
  input  logic [31:0] conf0,
  input  logic [31:0] conf1,
  input  logic [31:0] ele1,
  input  logic [31:0] ele2,
  output logic        SPI_MISO,
  output logic        SPI_MISO_oe
);

  // A deasserted chip select wipes the frame exactly like a reset does.
  logic frame_rstn;
  assign frame_rstn = resetn & ~SPI_CS;

  logic [5:0]  bit_cnt;
  logic [7:0]  cmd;
  logic        rd_act;
  logic [38:0] shift;
  logic [31:0] sel_word;
  logic        is_read;

  function automatic logic [7:0] crc8(input logic [31:0] word);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb  = crc[7] ^ word[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    end
    return crc;
  endfunction

  always_comb begin
    sel_word = conf0;
    case (cmd[1:0])
      2'b00:   sel_word = conf0;
      2'b01:   sel_word = conf1;
      2'b10:   sel_word = ele1;
      default: sel_word = ele2;
    endcase
  end

  assign is_read = (cmd[7:2] == RD_OPCODE);

  always_ff @(posedge SPI_Clk or negedge frame_rstn) begin
    if (!frame_rstn) begin
      bit_cnt <= 6'd0;
      cmd     <= 8'h00;
    end else begin
      if (bit_cnt != 6'd63)
        bit_cnt <= bit_cnt + 6'd1;
      if (bit_cnt < 6'd8)
        cmd <= {cmd[6:0], SPI_MOSI};
    end
  end

  // Bit 31 goes straight to MISO at decode, so shift only holds what follows it.
  always_ff @(negedge SPI_Clk or negedge frame_rstn) begin
    if (!frame_rstn) begin
      rd_act   <= 1'b0;
      shift    <= '0;
      SPI_MISO <= 1'b0;
    end else if (bit_cnt == 6'd8) begin
      rd_act <= is_read;
      if (is_read) begin
        shift    <= {sel_word[30:0], crc8(sel_word)};
        SPI_MISO <= sel_word[31];
      end else begin
        SPI_MISO <= 1'b0;
      end
    end else if (bit_cnt >= 6'd48) begin
      SPI_MISO <= 1'b0;
    end else if (bit_cnt >= 6'd9 && rd_act) begin
      shift    <= {shift[37:0], 1'b0};
      SPI_MISO <= shift[38];
    end
  end

  assign SPI_MISO_oe = rd_act & ~SPI_CS;

endmodule
